// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache, one outstanding fetch
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_responder #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ins_asked,
    input  logic [31:0] ins_addr,
    output logic        ic_rdy,
    output logic [31:0] ins,
    output logic        mem_ask,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [31:0]             data_q [LINES];
    logic                    ic_rdy_q, ic_rdy_d;
    logic [31:0]             ins_q, ins_d;
    logic                    mem_ask_q, mem_ask_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]        miss_tag_q, miss_tag_d;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    lookup_hit;
    logic                    fill_en;
    logic                    hit_evt;
    logic                    miss_evt;
    logic                    unused_addr_bits;

    assign req_idx          = ins_addr[INDEX_BITS+1:2];
    assign req_tag          = ins_addr[31:INDEX_BITS+2];
    assign lookup_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^ins_addr[1:0];

    always_comb begin
        state_d    = state_q;
        ic_rdy_d   = 1'b0;
        ins_d      = ins_q;
        mem_ask_d  = mem_ask_q;
        mem_addr_d = mem_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        fill_en    = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ins_asked) begin
                    if (lookup_hit) begin
                        ins_d    = data_q[req_idx];
                        ic_rdy_d = 1'b1;
                        hit_evt  = 1'b1;
                    end else begin
                        mem_ask_d  = 1'b1;
                        mem_addr_d = {ins_addr[31:2], 2'b00};
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        miss_evt   = 1'b1;
                        state_d    = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                // New requests are not looked at here; the fetcher waits for ic_rdy.
                if (mem_rdy) begin
                    fill_en   = 1'b1;
                    ins_d     = mem_data;
                    ic_rdy_d  = 1'b1;
                    mem_ask_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            ic_rdy_q   <= 1'b0;
            ins_q      <= '0;
            mem_ask_q  <= 1'b0;
            mem_addr_q <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            ic_rdy_q   <= ic_rdy_d;
            ins_q      <= ins_d;
            mem_ask_q  <= mem_ask_d;
            mem_addr_q <= mem_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            if (fill_en) begin
                valid_q[miss_idx_q] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= mem_data;
        end
    end

    assign ic_rdy   = ic_rdy_q;
    assign ins      = ins_q;
    assign mem_ask  = mem_ask_q;
    assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            if (hit_evt) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_evts;
    assign unused_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - directed-vector bench for icache_responder
// Counter checks are included when ICACHE_PERF_CNT_EN is defined.
module tb_icache_responder;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ins_asked;
    logic [31:0] ins_addr;
    logic        ic_rdy;
    logic [31:0] ins;
    logic        mem_ask;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int vec_cnt;
    int err_cnt;

    icache_responder #(.INDEX_BITS(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .ins_asked (ins_asked),
        .ins_addr  (ins_addr),
        .ic_rdy    (ic_rdy),
        .ins       (ins),
        .mem_ask   (mem_ask),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .mem_data  (mem_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A request is only legal while no miss is outstanding.
    task automatic req(input logic [31:0] a);
        check_vec("req_while_idle", {31'd0, mem_ask}, 32'd0);
        ins_asked = 1'b1;
        ins_addr  = a;
        step();
        ins_asked = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d, input int wait_cycles);
        repeat (wait_cycles) step();
        mem_rdy  = 1'b1;
        mem_data = d;
        step();
        mem_rdy  = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] d);
        req(a);
        check_vec("miss_mem_ask", {31'd0, mem_ask}, 32'd1);
        check_vec("miss_mem_addr", mem_addr, {a[31:2], 2'b00});
        check_vec("miss_no_early_rdy", {31'd0, ic_rdy}, 32'd0);
        serve(d, 2);
        check_vec("miss_ic_rdy", {31'd0, ic_rdy}, 32'd1);
        check_vec("miss_ins", ins, d);
        check_vec("miss_ask_drop", {31'd0, mem_ask}, 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
        req(a);
        check_vec("hit_ic_rdy", {31'd0, ic_rdy}, 32'd1);
        check_vec("hit_ins", ins, d);
        check_vec("hit_no_mem_ask", {31'd0, mem_ask}, 32'd0);
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        rdy       = 1'b1;
        ins_asked = 1'b0;
        ins_addr  = '0;
        mem_rdy   = 1'b0;
        mem_data  = '0;
        step();
        step();
        rst = 1'b0;
        check_vec("rst_ic_rdy", {31'd0, ic_rdy}, 32'd0);
        check_vec("rst_mem_ask", {31'd0, mem_ask}, 32'd0);
        check_vec("rst_mem_addr", mem_addr, 32'd0);
        check_vec("rst_ins", ins, 32'd0);

        // Cold miss, then a hit on the same word through a different byte offset
        do_miss(32'h0000_0000, 32'h0000_0013);
        step();
        check_vec("pulse_one_cycle", {31'd0, ic_rdy}, 32'd0);
        check_vec("ins_held", ins, 32'h0000_0013);
        do_hit(32'h0000_0002, 32'h0000_0013);

        // Conflict eviction on index 1
        do_miss(32'h0000_0004, 32'h1111_1111);
        do_hit(32'h0000_0004, 32'h1111_1111);
        do_miss(32'h0000_0104, 32'hDEAD_BEEF);
        do_miss(32'h0000_0004, 32'h2222_2222);
        do_hit(32'h0000_0000, 32'h0000_0013);

        // rdy stall in MISS_WAIT with mem_rdy pulses that must be ignored
        req(32'h0000_0200);
        check_vec("stall_setup_ask", {31'd0, mem_ask}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rdy  = (i % 2 == 1);
            mem_data = 32'h0BAD_0BAD;
            step();
            check_vec("stall_mem_ask", {31'd0, mem_ask}, 32'd1);
            check_vec("stall_ic_rdy", {31'd0, ic_rdy}, 32'd0);
            check_vec("stall_mem_addr", mem_addr, 32'h0000_0200);
        end
        rdy     = 1'b1;
        mem_rdy = 1'b0;
        step();
        check_vec("resume_still_wait", {31'd0, mem_ask}, 32'd1);
        check_vec("resume_no_rdy", {31'd0, ic_rdy}, 32'd0);
        serve(32'hCAFE_0001, 0);
        check_vec("stall_done_rdy", {31'd0, ic_rdy}, 32'd1);
        check_vec("stall_done_ins", ins, 32'hCAFE_0001);
        rdy = 1'b0;
        step();
        check_vec("pulse_held_rdy0", {31'd0, ic_rdy}, 32'd1);
        rdy = 1'b1;
        step();
        check_vec("pulse_drop_rdy1", {31'd0, ic_rdy}, 32'd0);
        do_hit(32'h0000_0200, 32'hCAFE_0001);

        // Reset in MISS_WAIT abandons the miss and invalidates every line
        req(32'h0000_0300);
        check_vec("rstmiss_ask", {31'd0, mem_ask}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_vec("rstmiss_ask_clr", {31'd0, mem_ask}, 32'd0);
        check_vec("rstmiss_addr_clr", mem_addr, 32'd0);
        check_vec("rstmiss_ins_clr", ins, 32'd0);
        mem_rdy  = 1'b1;
        mem_data = 32'h5555_5555;
        step();
        mem_rdy = 1'b0;
        check_vec("late_mem_rdy_ignored", {31'd0, ic_rdy}, 32'd0);
        check_vec("late_mem_rdy_ins", ins, 32'd0);
        do_miss(32'h0000_0200, 32'h7777_7777);
        do_miss(32'h0000_0104, 32'h8888_8888);

        // Fresh reset, then 3 misses and 5 hits
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_miss(32'h0000_0010, 32'hA000_0010);
        do_miss(32'h0000_0014, 32'hA000_0014);
        do_miss(32'h0000_0018, 32'hA000_0018);
        do_hit(32'h0000_0010, 32'hA000_0010);
        do_hit(32'h0000_0014, 32'hA000_0014);
        do_hit(32'h0000_0018, 32'hA000_0018);
        do_hit(32'h0000_0010, 32'hA000_0010);
        do_hit(32'h0000_0012, 32'hA000_0010);
        step();
`ifdef ICACHE_PERF_CNT_EN
        check_vec("hit_cnt", hit_cnt, 32'd5);
        check_vec("miss_cnt", miss_cnt, 32'd3);
`endif
        check_vec("end_idle_ask", {31'd0, mem_ask}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
